// File: rtl/reset_sequencer.sv
// Power-up / lock-loss reset sequencer for the Hack fabric.
// Synchronizes the PLL lock and the reset button, waits for a stable lock,
// holds reset for a fixed time, then releases the system. It re-enters
// reset on filtered lock loss or on a button press.
module reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int LOSS_FILTER   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       btn_n,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] relock_count
);

  // One shared counter serves both STABLE and HOLD.
  // It is at least one bit wide, so the degenerate 1-cycle settings stay legal.
  localparam int CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int LOSS_W  = $clog2(LOSS_FILTER + 1);

  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN
  } state_t;

  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   lock_s;
  logic                   btn_s;

  state_t      state;
  state_t      state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [LOSS_W-1:0] loss_cnt;
  logic [LOSS_W-1:0] loss_next;
  logic [7:0]        relock_next;

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign btn_s  = btn_sync[SYNC_STAGES-1];

  // Metastability chains. After reset they read "lock lost" and "button released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= '0;
      btn_sync  <= '1;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_n};
    end
  end

  // Next-state logic. A pressed button overrides everything, including a lock-loss completion.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    loss_next   = loss_cnt;
    relock_next = relock_count;
    if (!btn_s) begin
      state_next = WAIT_LOCK;
      cnt_next   = '0;
      loss_next  = '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt_next  = '0;
          loss_next = '0;
          if (lock_s) state_next = STABLE;
        end
        STABLE: begin
          loss_next = '0;
          if (!lock_s) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_next = HOLD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          loss_next = '0;
          if (!lock_s) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt == HOLD_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_next = '0;
          if (lock_s) begin
            loss_next = '0;
          end else if (loss_cnt == LOSS_LAST) begin
            state_next = WAIT_LOCK;
            loss_next  = '0;
            if (relock_count != 8'hFF) relock_next = relock_count + 8'd1;
          end else begin
            loss_next = loss_cnt + LOSS_W'(1);
          end
        end
        default: begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
          loss_next  = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  // The outputs are driven from the next state, so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      loss_cnt     <= '0;
      relock_count <= 8'd0;
      sys_reset    <= 1'b1;
      ready        <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      loss_cnt     <= loss_next;
      relock_count <= relock_next;
      sys_reset    <= (state_next != RUN);
      ready        <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer.
// The DUT is compared every cycle against a streak-counting reference model.
// Directed scenarios, pinned with literal expectations, are followed by a randomized run.
module tb_reset_sequencer;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 8;
  localparam int HOLD_CYCLES   = 4;
  localparam int LOSS_FILTER   = 2;
  // Consecutive good samples needed to go from "not running" to "running".
  localparam int GOOD_NEEDED   = 1 + STABLE_CYCLES + HOLD_CYCLES;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       locked = 1'b0;
  logic       btn_n = 1'b1;
  logic       sys_reset;
  logic       ready;
  logic [7:0] relock_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state: input delay pipes plus streak counters.
  logic [SYNC_STAGES-1:0] m_lpipe;
  logic [SYNC_STAGES-1:0] m_bpipe;
  bit m_running;
  int m_streak;
  int m_lows;
  int m_relocks;

  reset_sequencer #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .LOSS_FILTER  (LOSS_FILTER)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .locked      (locked),
    .btn_n       (btn_n),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .relock_count(relock_count)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Reference model.
  // Running starts after GOOD_NEEDED consecutive synchronized samples with the lock high and the button released.
  // It stops after LOSS_FILTER consecutive low lock samples, or as soon as the button is seen pressed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lpipe   <= '0;
      m_bpipe   <= '1;
      m_running <= 1'b0;
      m_streak  <= 0;
      m_lows    <= 0;
      m_relocks <= 0;
    end else begin
      m_lpipe <= {m_lpipe[SYNC_STAGES-2:0], locked};
      m_bpipe <= {m_bpipe[SYNC_STAGES-2:0], btn_n};
      if (!m_bpipe[SYNC_STAGES-1]) begin
        m_running <= 1'b0;
        m_streak  <= 0;
        m_lows    <= 0;
      end else if (!m_running) begin
        if (m_lpipe[SYNC_STAGES-1]) begin
          if (m_streak + 1 == GOOD_NEEDED) begin
            m_running <= 1'b1;
            m_streak  <= 0;
            m_lows    <= 0;
          end else begin
            m_streak <= m_streak + 1;
          end
        end else begin
          m_streak <= 0;
        end
      end else begin
        if (!m_lpipe[SYNC_STAGES-1]) begin
          if (m_lows + 1 == LOSS_FILTER) begin
            m_running <= 1'b0;
            m_lows    <= 0;
            m_streak  <= 0;
            m_relocks <= (m_relocks < 255) ? m_relocks + 1 : 255;
          end else begin
            m_lows <= m_lows + 1;
          end
        end else begin
          m_lows <= 0;
        end
      end
    end
  end

  // Per-cycle compare of all DUT outputs against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if ({sys_reset, ready, relock_count} !== {~m_running, m_running, 8'(m_relocks)}) begin
        errors++;
        $display("[TB] FAIL cycle_model t=%0t got sys_reset=%0b ready=%0b relock=%0d want sys_reset=%0b ready=%0b relock=%0d",
                 $time, sys_reset, ready, relock_count, ~m_running, m_running, m_relocks);
      end
    end
  end

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse the asynchronous reset across two edges. Edge 1 is the next rising edge after return.
  task automatic apply_stimulus_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Compare the DUT and the model against literal expectations.
  task automatic check_output(input string name, input logic exp_rst, input logic exp_rdy, input int exp_rel);
    checks++;
    if (sys_reset !== exp_rst || ready !== exp_rdy || relock_count !== 8'(exp_rel)) begin
      errors++;
      $display("[TB] FAIL %s dut got sys_reset=%0b ready=%0b relock=%0d want %0b %0b %0d",
               name, sys_reset, ready, relock_count, exp_rst, exp_rdy, exp_rel);
    end
    checks++;
    if (m_running !== exp_rdy || m_relocks != exp_rel) begin
      errors++;
      $display("[TB] FAIL %s model got running=%0b relock=%0d want %0b %0d",
               name, m_running, m_relocks, exp_rdy, exp_rel);
    end
  endtask

  int btn_left;

  initial begin
    // Power-up: reset asserted with the lock already high.
    #2;
    rst_n  = 1'b0;
    locked = 1'b1;
    btn_n  = 1'b1;
    #1;
    cmp_en = 1'b1;
    check_output("reset_state", 1'b1, 1'b0, 0);
    step(3);
    rst_n = 1'b1;
    step(14);
    check_output("powerup_edge14", 1'b1, 1'b0, 0);
    step(1);
    check_output("powerup_edge15", 1'b0, 1'b1, 0);

    // Lock chatter in STABLE restarts the whole count.
    apply_stimulus_reset();
    step(6);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(14);
    check_output("chatter_edge21", 1'b1, 1'b0, 0);
    step(1);
    check_output("chatter_edge22", 1'b0, 1'b1, 0);

    // A single-cycle glitch in RUN is filtered out.
    step(3);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(6);
    check_output("glitch_1cycle", 1'b0, 1'b1, 0);

    // A three-cycle low in RUN is lock loss, followed by relock.
    locked = 1'b0;
    step(3);
    check_output("loss_k2", 1'b0, 1'b1, 0);
    locked = 1'b1;
    step(1);
    check_output("loss_k3", 1'b1, 1'b0, 1);
    step(13);
    check_output("relock_k16", 1'b1, 1'b0, 1);
    step(1);
    check_output("relock_k17", 1'b0, 1'b1, 1);

    // A 20-cycle button press in RUN.
    step(2);
    btn_n = 1'b0;
    step(2);
    check_output("btn_j1", 1'b0, 1'b1, 1);
    step(1);
    check_output("btn_j2", 1'b1, 1'b0, 1);
    for (int i = 0; i < 17; i++) begin
      step(1);
      check_output("btn_held", 1'b1, 1'b0, 1);
    end
    btn_n = 1'b1;
    step(14);
    check_output("btn_rel_j33", 1'b1, 1'b0, 1);
    step(1);
    check_output("btn_rel_j34", 1'b0, 1'b1, 1);

    // Second lock loss, then an asynchronous reset pulse while in HOLD.
    step(2);
    locked = 1'b0;
    step(3);
    locked = 1'b1;
    step(13);
    check_output("mid_hold", 1'b1, 1'b0, 2);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", 1'b1, 1'b0, 0);
    #1;
    rst_n = 1'b1;
    step(20);
    check_output("rerun_after_async", 1'b0, 1'b1, 0);

    // Saturation of relock_count.
    for (int i = 0; i < 260; i++) begin
      locked = 1'b0;
      step(3);
      locked = 1'b1;
      step(16);
      if (i == 253) check_output("sat_254", 1'b0, 1'b1, 254);
      if (i == 254) check_output("sat_255", 1'b0, 1'b1, 255);
    end
    check_output("sat_260", 1'b0, 1'b1, 255);

    // Randomized lock chatter and button presses, checked by the per-cycle compare.
    apply_stimulus_reset();
    btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if (btn_left > 0) btn_left--;
      else if ($urandom_range(99) == 0) btn_left = $urandom_range(30, 1);
      btn_n = (btn_left == 0);
      if (locked) begin
        if ($urandom_range(99) < 3) locked = 1'b0;
      end else begin
        if ($urandom_range(99) < 35) locked = 1'b1;
      end
    end
    step(2);
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
